// File: rtl/powlib_bus_pkg.sv
// Shared definitions for the powlib bus blocks: arbiter FSM state
// encodings and a constant-width helper.
package powlib_bus_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } bus_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Enabled register with asynchronous active-high reset to zero.
module powlib_flipflop #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/powlib_rrpick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo W.
module powlib_rrpick #(
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (!found && req[(int'(ptr) + k) % W]) begin
                found                         = 1'b1;
                onehot[(int'(ptr) + k) % W]   = 1'b1;
                idx                           = IW'((int'(ptr) + k) % W);
            end
        end
    end

endmodule

// File: rtl/powlib_busarbiter.sv
// Round-robin bus arbiter: grants one requester for up to MAXB beats,
// discards out-of-range beats with an error pulse, registered output stage.
module powlib_busarbiter
    import powlib_bus_pkg::*;
#(
    parameter int  B_WRS  = 4,
    parameter int  B_AW   = 4,
    parameter int  B_DW   = 8,
    parameter int  B_BASE = 4,
    parameter int  B_SIZE = 3,
    parameter int  MAXB   = 2,
    localparam int SW     = (clog2(B_WRS) > 0) ? clog2(B_WRS) : 1,
    localparam int CW     = clog2(MAXB + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [B_WRS*B_DW-1:0] wrdatas,
    input  logic [B_WRS*B_AW-1:0] wraddrs,
    input  logic [B_WRS-1:0]      wrvlds,
    output logic [B_WRS-1:0]      wrrdys,
    output logic [B_WRS-1:0]      wrerrs,
    output logic [B_DW-1:0]       rddata,
    output logic [B_AW-1:0]       rdaddr,
    output logic [SW-1:0]         rdsrc,
    output logic                  rdvld,
    input  logic                  rdrdy
);

    // Handshake: a requester beat moves on wrvlds[i] && wrrdys[i]; the output
    // beat moves on rdvld && rdrdy, and rdvld/data hold while rdrdy is low.

    localparam logic [B_AW:0] ADDR_LO = (B_AW+1)'(B_BASE);
    localparam logic [B_AW:0] ADDR_HI = (B_AW+1)'(B_BASE + B_SIZE);

    bus_state_e    state_q, state_d;
    logic [SW-1:0] g_q, g_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [B_WRS-1:0] inr, reqs, oor, pick_oh, gnt_oh;
    logic [SW-1:0]    pick_idx, xsrc;
    logic             adv, xfer;

    logic             rdvld_d, rdvld_q;
    logic [B_DW-1:0]  rddata_d, rddata_q;
    logic [B_AW-1:0]  rdaddr_d, rdaddr_q;
    logic [SW-1:0]    rdsrc_d, rdsrc_q;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] x);
        return (x == SW'(B_WRS - 1)) ? '0 : x + SW'(1);
    endfunction

    always_comb begin
        inr = '0;
        for (int i = 0; i < B_WRS; i++) begin
            inr[i] = ({1'b0, wraddrs[i*B_AW +: B_AW]} >= ADDR_LO) &&
                     ({1'b0, wraddrs[i*B_AW +: B_AW]} <= ADDR_HI);
        end
    end

    assign reqs = wrvlds & inr;
    assign oor  = wrvlds & ~inr;
    assign adv  = !rdvld_q || rdrdy;

    powlib_rrpick #(.W(B_WRS), .IW(SW)) u_pick (
        .req    (reqs),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        xfer    = 1'b0;
        xsrc    = g_q;
        gnt_oh  = '0;
        case (state_q)
            ST_IDLE: begin
                if (adv && (|reqs)) begin
                    xfer   = 1'b1;
                    xsrc   = pick_idx;
                    gnt_oh = pick_oh;
                    g_d    = pick_idx;
                    cnt_d  = CW'(1);
                    if (MAXB > 1) state_d = ST_BURST;
                    else          ptr_d   = next_idx(pick_idx);
                end
            end
            ST_BURST: begin
                // A dropped valid, an out-of-range beat or a full burst all
                // release the grant and cost one bubble cycle.
                if (!reqs[g_q] || (cnt_q == CW'(MAXB))) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_idx(g_q);
                end else if (adv) begin
                    xfer        = 1'b1;
                    gnt_oh[g_q] = 1'b1;
                    cnt_d       = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wrrdys = rst ? '0 : (oor | gnt_oh);
    assign wrerrs = rst ? '0 : oor;

    assign rdvld_d  = xfer;
    assign rddata_d = wrdatas[int'(xsrc)*B_DW +: B_DW];
    assign rdaddr_d = wraddrs[int'(xsrc)*B_AW +: B_AW];
    assign rdsrc_d  = xsrc;

    powlib_flipflop #(.W(1)) u_vld (
        .clk(clk), .rst(rst), .en(adv), .d(rdvld_d), .q(rdvld_q)
    );
    powlib_flipflop #(.W(B_DW)) u_data (
        .clk(clk), .rst(rst), .en(xfer), .d(rddata_d), .q(rddata_q)
    );
    powlib_flipflop #(.W(B_AW)) u_addr (
        .clk(clk), .rst(rst), .en(xfer), .d(rdaddr_d), .q(rdaddr_q)
    );
    powlib_flipflop #(.W(SW)) u_src (
        .clk(clk), .rst(rst), .en(xfer), .d(rdsrc_d), .q(rdsrc_q)
    );

    assign rdvld  = rdvld_q;
    assign rddata = rddata_q;
    assign rdaddr = rdaddr_q;
    assign rdsrc  = rdsrc_q;

endmodule

// File: tb/tb_powlib_busarbiter.sv
// Bench for powlib_busarbiter: directed scenarios followed by random traffic,
// checked against a requester-level arbitration model and a beat queue.
module tb_powlib_busarbiter;

    localparam int NW   = 4;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int BASE = 4;
    localparam int SIZE = 3;
    localparam int MAXB = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW*DW-1:0]  wrdatas;
    logic [NW*AW-1:0]  wraddrs;
    logic [NW-1:0]     wrvlds;
    logic [NW-1:0]     wrrdys;
    logic [NW-1:0]     wrerrs;
    logic [DW-1:0]     rddata;
    logic [AW-1:0]     rdaddr;
    logic [1:0]        rdsrc;
    logic              rdvld;
    logic              rdrdy;

    logic [DW-1:0]     d_in [NW];
    logic [AW-1:0]     a_in [NW];
    logic [NW-1:0]     v_in;

    int                checks = 0;
    int                errors = 0;

    // model: current owner (-1 when nobody holds a grant), beats taken, search start
    int                m_owner;
    int                m_beats;
    int                m_start;
    logic [13:0]       exp_q[$];   // {src, addr, data} awaiting output handshake
    int                src_log[$];
    bit                log_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            wrdatas[i*DW +: DW] = d_in[i];
            wraddrs[i*AW +: AW] = a_in[i];
        end
    end
    assign wrvlds = v_in;

    powlib_busarbiter #(
        .B_WRS(NW), .B_AW(AW), .B_DW(DW), .B_BASE(BASE), .B_SIZE(SIZE), .MAXB(MAXB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wrdatas (wrdatas),
        .wraddrs (wraddrs),
        .wrvlds  (wrvlds),
        .wrrdys  (wrrdys),
        .wrerrs  (wrerrs),
        .rddata  (rddata),
        .rdaddr  (rdaddr),
        .rdsrc   (rdsrc),
        .rdvld   (rdvld),
        .rdrdy   (rdrdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
        return (int'(a) >= BASE) && (int'(a) <= BASE + SIZE);
    endfunction

    // One clock: compare at the negedge, advance the model, return at posedge+1.
    task automatic cycle();
        logic [NW-1:0] exp_rdy;
        logic [NW-1:0] exp_err;
        logic [13:0]   beat;
        int            xfer;
        int            j;
        bit            adv;
        @(negedge clk);
        if (rst) begin
            chk("rst_wrrdys", wrrdys, 0);
            chk("rst_wrerrs", wrerrs, 0);
            chk("rst_rdvld", rdvld, 0);
            chk("rst_rddata", rddata, 0);
            chk("rst_rdaddr", rdaddr, 0);
            chk("rst_rdsrc", rdsrc, 0);
            exp_q.delete();
            m_owner = -1;
            m_beats = 0;
            m_start = 0;
        end else begin
            if (log_en) src_log.push_back(rdvld ? int'(rdsrc) : 9);
            chk("rdvld", rdvld, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                beat = exp_q[0];
                chk("rdsrc", rdsrc, beat[13:12]);
                chk("rdaddr", rdaddr, beat[11:8]);
                chk("rddata", rddata, beat[7:0]);
            end
            adv = (exp_q.size() == 0) || rdrdy;
            if (exp_q.size() != 0 && rdrdy) void'(exp_q.pop_front());

            exp_err = '0;
            for (int i = 0; i < NW; i++)
                if (v_in[i] && !in_range(a_in[i])) exp_err[i] = 1'b1;

            xfer = -1;
            if (m_owner < 0) begin
                if (adv) begin
                    for (int k = 0; k < NW; k++) begin
                        j = (m_start + k) % NW;
                        if (xfer < 0 && v_in[j] && in_range(a_in[j])) xfer = j;
                    end
                end
                if (xfer >= 0) begin
                    if (MAXB > 1) begin
                        m_owner = xfer;
                        m_beats = 1;
                    end else begin
                        m_start = (xfer + 1) % NW;
                    end
                end
            end else if (!v_in[m_owner] || !in_range(a_in[m_owner]) || m_beats >= MAXB) begin
                m_start = (m_owner + 1) % NW;
                m_owner = -1;
            end else if (adv) begin
                xfer = m_owner;
                m_beats++;
            end

            exp_rdy = exp_err;
            if (xfer >= 0) exp_rdy[xfer] = 1'b1;
            chk("wrrdys", wrrdys, exp_rdy);
            chk("wrerrs", wrerrs, exp_err);
            if (xfer >= 0) exp_q.push_back({2'(xfer), a_in[xfer], d_in[xfer]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [NW-1:0] v, input logic [AW-1:0] a);
        for (int i = 0; i < NW; i++) begin
            a_in[i] = a;
            d_in[i] = DW'($urandom);
        end
        v_in = v;
    endtask

    initial begin
        int exp_ord[14] = '{9, 0, 0, 9, 1, 1, 9, 2, 2, 9, 3, 3, 9, 0};
        rst   = 1'b1;
        rdrdy = 1'b1;
        set_all('0, '0);
        repeat (2) cycle();
        rst = 1'b0;

        // idle after reset
        repeat (6) cycle();
        chk("idle_rdvld", rdvld, 0);
        chk("idle_wrrdys", wrrdys, 0);

        // everyone valid at an in-range address: two beats each, one bubble
        log_en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            set_all('1, 4'd5);
            cycle();
        end
        log_en = 1'b0;
        chk("order_len", src_log.size(), 14);
        for (int i = 0; i < 14 && i < src_log.size(); i++)
            chk($sformatf("order_%0d", i), src_log[i], exp_ord[i]);
        set_all('0, 4'd5);
        repeat (3) cycle();

        // out-of-range beat from requester 2 is discarded with an error
        set_all(4'b0100, 4'd9);
        d_in[2] = 8'hA5;
        cycle();
        chk("oor_rdy2", wrrdys[2], 1);
        chk("oor_err2", wrerrs[2], 1);
        chk("oor_no_load", rdvld, 0);
        set_all('0, 4'd5);
        cycle();
        chk("oor_err_pulse", wrerrs, 0);
        chk("oor_still_idle", rdvld, 0);

        // back-pressure: beat from requester 1 held until rdrdy
        rdrdy = 1'b0;
        set_all(4'b0010, 4'd7);
        d_in[1] = 8'h3C;
        cycle();
        set_all('0, 4'd7);
        for (int c = 0; c < 3; c++) begin
            chk("hold_vld", rdvld, 1);
            chk("hold_data", rddata, 8'h3C);
            chk("hold_src", rdsrc, 1);
            cycle();
        end
        rdrdy = 1'b1;
        cycle();
        chk("hold_release", rdvld, 0);

        // requester 3 drops after one beat; requester 0 follows after a bubble
        set_all(4'b1000, 4'd5);
        cycle();
        chk("drop_first_vld", rdvld, 1);
        chk("drop_first_src", rdsrc, 3);
        set_all(4'b0001, 4'd4);
        cycle();
        chk("drop_bubble", rdvld, 0);
        set_all(4'b0001, 4'd4);
        cycle();
        chk("drop_next_vld", rdvld, 1);
        chk("drop_next_src", rdsrc, 0);

        // reset mid-burst drops the beat; search restarts from requester 0
        set_all(4'b1100, 4'd6);
        repeat (2) cycle();
        chk("pre_rst_vld", rdvld, 1);
        chk("pre_rst_src", rdsrc, 2);
        rst = 1'b1;
        #1;
        chk("rst_async_vld", rdvld, 0);
        cycle();
        rst = 1'b0;
        set_all(4'b1010, 4'd5);
        cycle();
        chk("post_rst_vld", rdvld, 1);
        chk("post_rst_src", rdsrc, 1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            rdrdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NW; i++) begin
                v_in[i] = ($urandom_range(0, 9) < 6);
                a_in[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15))
                                                      : AW'($urandom_range(BASE, BASE + SIZE));
                d_in[i] = DW'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        set_all('0, '0);
        rdrdy = 1'b1;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
